soc_bus_fabric: RTL

Parametrised bus fabric between the FemtoRV32 core and N memory-mapped slaves (memory, gpio_ip, uart_ip, i2c_master_ip, future IPs). It replaces the fixed four-way device decode and combinational read mux with the following:
- a table-driven region decoder;
- a registered read path;
- per-slave ready/valid wait-state support via `m_rbusy`/`m_wbusy`;
- a timeout and unmapped-address error response with sticky error status.

---
 rtl/soc_bus_fabric.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/soc_bus_fabric.sv
// soc_bus_fabric: table-decoded bus fabric between the FemtoRV32 core and N slaves,
// with a registered read path, wait-state handling, timeout and sticky error status.
module soc_bus_fabric #(
    parameter int                                        N_SLAVES       = 4,
    parameter int                                        SEL_MSB        = 31,
    parameter int                                        SEL_LSB        = 28,
    parameter logic [N_SLAVES*(SEL_MSB-SEL_LSB+1)-1:0]   SLAVE_REGION   = {4'h3, 4'h2, 4'h1, 4'h0},
    parameter int                                        TIMEOUT_CYCLES = 255,
    parameter logic [31:0]                               ERR_RDATA      = 32'hDEADBEEF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [31:0]            m_addr,
    input  logic [31:0]            m_wdata,
    input  logic [3:0]             m_wmask,
    input  logic                   m_rstrb,
    output logic [31:0]            m_rdata,
    output logic                   m_rbusy,
    output logic                   m_wbusy,
    output logic [31:0]            s_addr,
    output logic [31:0]            s_wdata,
    output logic [3:0]             s_wstrb,
    output logic [N_SLAVES-1:0]    s_wen,
    output logic [N_SLAVES-1:0]    s_ren,
    input  logic [32*N_SLAVES-1:0] s_rdata,
    input  logic [N_SLAVES-1:0]    s_rvalid,
    input  logic [N_SLAVES-1:0]    s_wready,
    input  logic                   err_clr,
    output logic                   err_irq,
    output logic [31:0]            err_addr,
    output logic [7:0]             err_count
);

    localparam int REGION_W = SEL_MSB - SEL_LSB + 1;
    localparam int IDX_W    = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [31:0] LOW_MASK = (32'h1 << SEL_LSB) - 32'h1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        WR_WAIT  = 2'd2,
        ERR_RESP = 2'd3
    } state_t;

    state_t                state, state_next;
    logic [REGION_W-1:0]   region;
    logic                  hit;
    logic [IDX_W-1:0]      hit_idx;
    logic [N_SLAVES-1:0]   hit_onehot;
    logic [IDX_W-1:0]      sel_idx;
    logic                  op_read;
    logic [31:0]           req_addr;
    logic [CNT_W-1:0]      wait_cnt;
    logic                  timeout;
    logic                  wr_req, rd_req;
    logic                  req_accept, req_is_read, cnt_clr;
    logic                  rd_load, err_evt;
    logic [31:0]           rd_val;

    assign s_addr  = m_addr & LOW_MASK;
    assign s_wdata = m_wdata;
    assign s_wstrb = m_wmask;

    assign region = m_addr[SEL_MSB:SEL_LSB];
    assign wr_req = |m_wmask;
    assign rd_req = m_rstrb;

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (region == SLAVE_REGION[i*REGION_W +: REGION_W]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    assign hit_onehot = N_SLAVES'(1) << hit_idx;
    assign timeout    = (TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_LAST);
    assign m_rbusy    = (state == RD_WAIT) || ((state == ERR_RESP) && op_read);
    assign m_wbusy    = (state == WR_WAIT) || ((state == ERR_RESP) && !op_read);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Enables are gated by reset_n so nothing reaches a slave while held in reset.
    always_comb begin
        state_next  = state;
        s_wen       = '0;
        s_ren       = '0;
        req_accept  = 1'b0;
        req_is_read = 1'b0;
        cnt_clr     = 1'b0;
        rd_load     = 1'b0;
        rd_val      = ERR_RDATA;
        err_evt     = 1'b0;
        case (state)
            IDLE: begin
                if (reset_n && wr_req) begin
                    req_accept = 1'b1;
                    if (hit) begin
                        s_wen      = hit_onehot;
                        cnt_clr    = 1'b1;
                        state_next = WR_WAIT;
                    end else begin
                        state_next = ERR_RESP;
                    end
                end else if (reset_n && rd_req) begin
                    req_accept  = 1'b1;
                    req_is_read = 1'b1;
                    if (hit) begin
                        s_ren      = hit_onehot;
                        cnt_clr    = 1'b1;
                        state_next = RD_WAIT;
                    end else begin
                        state_next = ERR_RESP;
                    end
                end
            end
            RD_WAIT: begin
                if (s_rvalid[sel_idx]) begin
                    rd_load    = 1'b1;
                    rd_val     = s_rdata[sel_idx*32 +: 32];
                    state_next = IDLE;
                end else if (timeout) begin
                    rd_load    = 1'b1;
                    err_evt    = 1'b1;
                    state_next = IDLE;
                end
            end
            WR_WAIT: begin
                if (s_wready[sel_idx]) begin
                    state_next = IDLE;
                end else if (timeout) begin
                    err_evt    = 1'b1;
                    state_next = IDLE;
                end
            end
            ERR_RESP: begin
                rd_load    = op_read;
                err_evt    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Transaction context is captured at acceptance so later checks use the original request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_idx  <= '0;
            op_read  <= 1'b0;
            req_addr <= '0;
            wait_cnt <= '0;
            m_rdata  <= '0;
        end else begin
            if (req_accept) begin
                sel_idx  <= hit_idx;
                op_read  <= req_is_read;
                req_addr <= m_addr;
            end
            if (cnt_clr)
                wait_cnt <= '0;
            else if (((state == RD_WAIT) || (state == WR_WAIT)) && (wait_cnt != '1))
                wait_cnt <= wait_cnt + 1'b1;
            if (rd_load)
                m_rdata <= rd_val;
        end
    end

    // A new error beats a simultaneous clear and restarts the status from this error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_irq   <= 1'b0;
            err_addr  <= '0;
            err_count <= '0;
        end else if (err_evt) begin
            err_irq <= 1'b1;
            if (!err_irq || err_clr)
                err_addr <= req_addr;
            if (err_clr)
                err_count <= 8'd1;
            else if (err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end else if (err_clr) begin
            err_irq   <= 1'b0;
            err_addr  <= '0;
            err_count <= '0;
        end
    end

endmodule
